// File: rtl/input_event_scheduler_if.sv
// input_event_scheduler_if
//   Event stream between the scheduler FIFO head and the CPU-side consumer.
//   ev_valid : FIFO head holds an event
//   ev_ready : consumer accepts the head while ev_valid is high
//   ev_data  : {level, channel[3:0]} of the head, 0 when empty
//   ev_count : FIFO occupancy
//   master = scheduler side, slave = consumer side.
interface input_event_scheduler_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [4:0] ev_data;
  logic [4:0] ev_count;

  modport master (output ev_valid, output ev_data, output ev_count, input ev_ready);
  modport slave  (input ev_valid, input ev_data, input ev_count, output ev_ready);
endinterface

// File: rtl/input_event_scheduler.sv
// input_event_scheduler
//   Debounces 16 stabilized input levels, filters rising/falling edges per
//   channel, and queues one event per accepted edge into a small FIFO read by
//   the CPU. Channels committing in the same cycle are served round-robin.
//   Ports:
//     clk, resetn          : clock, asynchronous active-low reset
//     s[15:0]              : stabilized input levels (clk domain)
//     cfg_we, cfg_rise,
//     cfg_fall             : one-cycle load of per-channel rise/fall enables
//     ovf_clr              : one-cycle pulse clearing the sticky overflow flag
//     ev                   : event stream (valid/ready/data/count), master side
//     irq                  : level interrupt, equal to ev_valid
//     overflow             : sticky, an event was lost by coalescing
module input_event_scheduler #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [15:0]                     s,
  input  logic                            cfg_we,
  input  logic [15:0]                     cfg_rise,
  input  logic [15:0]                     cfg_fall,
  input  logic                            ovf_clr,
  input_event_scheduler_if.master         ev,
  output logic                            irq,
  output logic                            overflow
);

  localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] DEPTH5   = 5'(FIFO_DEPTH);

  logic [15:0]   stable;
  logic [7:0]    cnt [16];
  logic [15:0]   pend;
  logic [15:0]   plvl;
  logic [15:0]   rise_en;
  logic [15:0]   fall_en;
  logic [3:0]    ptr;

  logic [15:0]   commit;
  logic [15:0]   qualify;

  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;

  logic          head_valid;
  logic          pop;
  logic          can_push;
  logic          push;
  logic          sel_found;
  logic [3:0]    sel_idx;
  logic [3:0]    cand;
  logic [15:0]   served;
  logic [4:0]    push_data;
  logic          coalesce;

  // A commit happens on the D-th consecutive differing sample; it only
  // becomes an event when the edge direction is enabled for that channel.
  always_comb begin
    commit  = '0;
    qualify = '0;
    for (int i = 0; i < 16; i++) begin
      commit[i]  = (s[i] != stable[i]) && (cnt[i] == CNT_LAST);
      qualify[i] = commit[i] && (s[i] ? rise_en[i] : fall_en[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable <= '0;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (s[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (commit[i]) begin
          stable[i] <= s[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rise_en <= '0;
      fall_en <= '0;
    end else if (cfg_we) begin
      rise_en <= cfg_rise;
      fall_en <= cfg_fall;
    end
  end

  // Round-robin pick: first pending channel at or above ptr, wrapping.
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    head_valid = (count != 5'd0);
    pop        = head_valid && ev.ev_ready;
    can_push   = (count != DEPTH5) || pop;
    sel_found  = 1'b0;
    sel_idx    = '0;
    cand       = '0;
    for (int k = 0; k < 16; k++) begin
      cand = ptr + 4'(k);
      if (!sel_found && pend[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    push      = can_push && sel_found;
    served    = push ? (16'h0001 << sel_idx) : 16'h0000;
    push_data = {plvl[sel_idx], sel_idx};
    // A new commit on a channel still pending (and not being served) merges
    // into the old one and loses an event.
    coalesce  = |(qualify & pend & ~served);
  end

  // A fresh commit on the channel being served re-arms it: set wins over clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend <= '0;
      plvl <= '0;
      ptr  <= '0;
    end else begin
      pend <= (pend & ~served) | qualify;
      for (int i = 0; i < 16; i++) begin
        if (qualify[i]) plvl[i] <= s[i];
      end
      if (push) ptr <= 4'(sel_idx + 4'd1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (coalesce) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally. When full with a
  // simultaneous pop, the write lands in the slot being vacated.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  assign ev.ev_valid = head_valid;
  assign ev.ev_data  = head_valid ? mem[rd_ptr] : 5'd0;
  assign ev.ev_count = count;
  assign irq         = head_valid;

endmodule

// File: tb/tb_input_event_scheduler.sv
// tb_input_event_scheduler
//   Directed bench for input_event_scheduler with DEBOUNCE_CYCLES=4 and
//   FIFO_DEPTH=8. Inputs change 1 time unit after a rising edge and outputs
//   are sampled at the same point.
module tb_input_event_scheduler;

  logic        clk;
  logic        resetn;
  logic [15:0] s;
  logic        cfg_we;
  logic [15:0] cfg_rise;
  logic [15:0] cfg_fall;
  logic        ovf_clr;
  logic        irq;
  logic        overflow;

  int checks;
  int errors;

  input_event_scheduler_if ev_if ();

  input_event_scheduler #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (8)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .s        (s),
    .cfg_we   (cfg_we),
    .cfg_rise (cfg_rise),
    .cfg_fall (cfg_fall),
    .ovf_clr  (ovf_clr),
    .ev       (ev_if),
    .irq      (irq),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [15:0] rise, input logic [15:0] fall);
    cfg_rise = rise;
    cfg_fall = fall;
    cfg_we   = 1'b1;
    tick(1);
    cfg_we   = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check_output({tag, "_valid"}, 16'(ev_if.ev_valid), 16'h0);
    check_output({tag, "_count"}, 16'(ev_if.ev_count), 16'h0);
  endtask

  task automatic check_head(input string tag, input logic [4:0] data, input logic [4:0] cnt);
    check_output({tag, "_valid"}, 16'(ev_if.ev_valid), 16'h1);
    check_output({tag, "_data"},  16'(ev_if.ev_data),  16'(data));
    check_output({tag, "_count"}, 16'(ev_if.ev_count), 16'(cnt));
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    resetn         = 1'b0;
    s              = 16'hFFFF;
    cfg_we         = 1'b0;
    cfg_rise       = '0;
    cfg_fall       = '0;
    ovf_clr        = 1'b0;
    ev_if.ev_ready = 1'b0;

    // Reset with all inputs high: every output low.
    #12;
    check_output("rst_valid",    16'(ev_if.ev_valid), 16'h0);
    check_output("rst_data",     16'(ev_if.ev_data),  16'h0);
    check_output("rst_count",    16'(ev_if.ev_count), 16'h0);
    check_output("rst_irq",      16'(irq),            16'h0);
    check_output("rst_overflow", 16'(overflow),       16'h0);

    // Release with all edges disabled: rising commits happen but queue nothing.
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick(10);
    check_empty("noen_rise");
    s = 16'h0000;
    tick(8);
    check_empty("noen_fall");

    // Debounce on channel 5 with only its rising edge enabled.
    cfg_write(16'h0020, 16'h0000);
    s[5] = 1'b1;
    tick(3);
    s[5] = 1'b0;
    tick(1);
    s[5] = 1'b1;
    tick(3);
    s[5] = 1'b0;
    tick(6);
    check_empty("glitch");
    check_output("glitch_irq", 16'(irq), 16'h0);

    s[5] = 1'b1;
    tick(4);
    check_output("deb_edge4_valid", 16'(ev_if.ev_valid), 16'h0);
    tick(1);
    check_head("deb_edge5", 5'h15, 5'd1);
    check_output("deb_irq", 16'(irq), 16'h1);
    tick(1);
    check_head("deb_hold", 5'h15, 5'd1);
    ev_if.ev_ready = 1'b1;
    tick(1);
    ev_if.ev_ready = 1'b0;
    check_empty("deb_pop");
    check_output("deb_empty_data", 16'(ev_if.ev_data), 16'h0);
    s = 16'h0000;
    tick(6);

    // Fresh reset so the round-robin pointer starts at 0.
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    cfg_write(16'hFFFF, 16'h0000);
    ev_if.ev_ready = 1'b1;
    s = 16'h1208;
    tick(5);
    check_head("arb_first", 5'h13, 5'd1);
    tick(1);
    check_head("arb_second", 5'h19, 5'd1);
    tick(1);
    check_head("arb_third", 5'h1C, 5'd1);
    tick(1);
    check_empty("arb_drain");

    // Single event on channel 5 moves the pointer to 6.
    s[5] = 1'b1;
    tick(5);
    check_head("arb_ch5", 5'h15, 5'd1);
    tick(1);
    check_empty("arb_ch5_drain");

    // Pair 2 and 10 from pointer 6: 10 is served first, then wrap to 2.
    s[2]  = 1'b1;
    s[10] = 1'b1;
    tick(5);
    check_head("pair_first", 5'h1A, 5'd1);
    tick(1);
    check_head("pair_second", 5'h12, 5'd1);
    tick(1);
    check_empty("pair_drain");

    // Edge filter: channel 7 falling only; a 10-cycle pulse gives one event.
    cfg_write(16'h0000, 16'h0080);
    s[7] = 1'b1;
    tick(10);
    check_empty("filt_rise");
    s[7] = 1'b0;
    tick(4);
    check_output("filt_edge4_valid", 16'(ev_if.ev_valid), 16'h0);
    tick(1);
    check_head("filt_fall", 5'h07, 5'd1);
    tick(4);
    check_empty("filt_once");

    // Fill: nine simultaneous rising commits with the consumer stalled.
    // Pointer is 8, so the order is 8,11,13,14,0,1,4,6 and 7 stays pending.
    ev_if.ev_ready = 1'b0;
    cfg_write(16'hFFFF, 16'h0000);
    s = 16'h7FFF;
    tick(12);
    check_output("full_count", 16'(ev_if.ev_count), 16'h8);
    tick(2);
    check_head("full_hold", 5'h18, 5'd8);
    check_output("full_no_ovf", 16'(overflow), 16'h0);

    // Falling commit on the retained channel coalesces and flags overflow.
    cfg_write(16'hFFFF, 16'h0080);
    s[7] = 1'b0;
    tick(3);
    check_output("ovf_before", 16'(overflow), 16'h0);
    tick(1);
    check_output("ovf_set", 16'(overflow), 16'h1);
    check_output("ovf_count", 16'(ev_if.ev_count), 16'h8);

    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check_output("ovf_clr", 16'(overflow), 16'h0);

    // One pop admits the retained event in the same cycle.
    ev_if.ev_ready = 1'b1;
    tick(1);
    ev_if.ev_ready = 1'b0;
    check_head("pop_refill", 5'h1B, 5'd8);

    // Drain four to leave 8 queued minus 4: heads were 11,13,14,0 -> next is 1.
    ev_if.ev_ready = 1'b1;
    tick(4);
    ev_if.ev_ready = 1'b0;
    check_head("drain4", 5'h11, 5'd4);

    // Asynchronous reset between edges clears everything at once.
    #2;
    resetn = 1'b0;
    #1;
    check_output("async_valid",    16'(ev_if.ev_valid), 16'h0);
    check_output("async_irq",      16'(irq),            16'h0);
    check_output("async_count",    16'(ev_if.ev_count), 16'h0);
    check_output("async_data",     16'(ev_if.ev_data),  16'h0);
    check_output("async_overflow", 16'(overflow),       16'h0);
    tick(2);
    resetn = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_event_scheduler.md
# input_event_scheduler

Collects level changes from the 16 synchronized outputs of the input stabilizer bank and schedules them as events for the CPU. It debounces each channel, filters edges per channel and queues one event per accepted edge. Events go into a small FIFO, arbitrated round-robin when several channels change in the same cycle. It sits between the stabilizer outputs and the CPU I/O bus and drives a level interrupt.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive differing samples required to accept a new level; legal range 1..255.
- FIFO_DEPTH, 8: event FIFO entries; power of two, legal range 2..16.

- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset; deassertion is synchronous to clk upstream.
- s  in  16  stabilized input levels, already in the clk domain.
- cfg_we  in  1  one-cycle pulse; loads rise_en/fall_en from cfg_rise/cfg_fall.
- cfg_rise  in  16  per-channel rising-edge enable.
- cfg_fall  in  16  per-channel falling-edge enable.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head when ev_valid is high.
- ev_data  out  5  {level, channel[3:0]} of the FIFO head; 0 when empty.
- ev_count  out  5  FIFO occupancy, 0..FIFO_DEPTH.
- irq  out  1  equals ev_valid.
- overflow  out  1  sticky flag: an event was lost.
- ovf_clr  in  1  one-cycle pulse; clears overflow.

## Operation
- Per channel i: stable[i] (reset 0), cnt[i] (reset 0), pend[i] (reset 0), plvl[i] (reset 0).
- Debounce per channel:
  - If s[i]==stable[i], cnt[i]<=0.
  - Otherwise, if cnt[i]==DEBOUNCE_CYCLES-1: stable[i]<=s[i] and cnt[i]<=0. This commits the new level.
  - Otherwise cnt[i] increments.
- A commit is qualifying if it is rising with rise_en[i]=1, or falling with fall_en[i]=1.
- On a qualifying commit: pend[i]<=1 and plvl[i]<=new level.
- If pend[i] was already 1 and is not being popped into the FIFO that cycle, the events coalesce. plvl takes the newest level and overflow<=1.
- rise_en and fall_en reset to 0, so all edges are disabled after reset.
- A cfg write does not clear pending bits and does not disturb debounce state.
- Because stable resets to 0, a channel held high through reset produces a rising commit DEBOUNCE_CYCLES edges after reset. It is queued only if rise_en is set by then.
- Scheduler: rotating pointer ptr[3:0], reset 0.
  - Each cycle where the FIFO will not be full and any pend bit is set, it selects the first set pend index at or above ptr, wrapping 15 to 0.
  - It pushes {plvl[idx], idx}, clears pend[idx] and sets ptr<=idx+1 (mod 16).
  - At most one push per cycle.
  - If a new qualifying commit hits the selected channel in the same cycle, the set wins: pend stays 1 with the new level, and no overflow is flagged.
- FIFO: a pop occurs when ev_valid&&ev_ready.
  - Push and pop may occur in the same cycle. When full, a pop in that cycle allows the push, so "will not be full" includes the pop.
  - When full with no pop, no push occurs and pend bits are retained.
- overflow: set on a coalesce, cleared by ovf_clr; a set wins over ovf_clr in the same cycle.

## Timing
- Reset values:
  - ev_valid=0, ev_data=0, ev_count=0, irq=0, overflow=0.
  - All internal state is 0; the FIFO is empty.
- Latency: s[i] differs from stable[i] on D=DEBOUNCE_CYCLES consecutive rising edges.
  - stable[i] and pend[i] update on the D-th edge.
  - Push occurs on edge D+1, and ev_valid/irq rise after it, assuming no contention and FIFO not full.
- A glitch lasting fewer than D edges produces no event, and cnt returns to 0 on the first matching sample.
- ev_data and ev_valid are registered FIFO head outputs. They are stable while ev_valid&&!ev_ready.
- After a pop, the next entry is presented on the following cycle with no bubble.
- ev_count updates on the same edge as the push or pop.
- Asserting resetn low mid-operation clears all state immediately, including queued events and overflow; the interrupt drops without waiting for clk.

## Test plan
- Reset: hold resetn=0 with s=16'hFFFF -> all outputs 0. Release with rise_en=0 -> no events ever; stable becomes all 1.
- Debounce, D=4, rise_en[5]=1:
  - s[5] high for 3 cycles, then low -> no event.
  - s[5] high for 4 cycles -> ev_valid rises 5 edges after the first high sample, ev_data=5'b1_0101.
- Arbitration: rise_en=16'hFFFF, ptr=0, channels 3, 9 and 12 commit on the same edge, ev_ready=1 -> ev_data sequence 0x13, 0x19, 0x1C on consecutive cycles. A subsequent simultaneous pair 2 and 10 yields 10 before 2.
- Edge filter: fall_en[7]=1, rise_en[7]=0, pulse s[7] high for 10 cycles with D=4 -> exactly one event, 5'b0_0111, at the falling commit.
- Full/overflow, FIFO_DEPTH=8, ev_ready=0:
  - 9 qualifying channel commits -> ev_count=8, one pend retained.
  - A second commit on the retained channel -> overflow=1.
  - ovf_clr -> overflow=0.
  - Popping one entry lets the retained event enter the FIFO the same cycle, so ev_count stays 8.
- Async reset mid-stream: with 4 queued events, drop resetn between clock edges -> ev_valid, irq and ev_count go to 0 immediately.
